// File: rtl/branch_resolver_if.sv
// Branch resolver handshake/data bundle.
//   slave  : execute-stage branch resolver (consumes i_*, drives o_*)
//   master : producer/consumer side (drives i_*, observes o_*)
// Groups the input entry (flags, opcode, PC, offset, prediction) and its
// valid/ready pair. It also groups the resolved output entry, its valid/ready
// pair, the flush request and the statistics counters.
interface branch_resolver_if #(
  parameter int WIDTH       = 32,
  parameter int COUNT_WIDTH = 16
);
  logic                   i_Flush;
  logic                   i_Valid;
  logic                   o_Ready;
  logic                   i_IsBranch;
  logic                   i_IsJump;
  logic [2:0]             i_BranchOp;
  logic                   i_EQ;
  logic                   i_GT;
  logic                   i_LT;
  logic [WIDTH-1:0]       i_PC;
  logic [WIDTH-1:0]       i_Offset;
  logic                   i_PredTaken;
  logic [WIDTH-1:0]       i_PredTarget;
  logic                   o_Valid;
  logic                   i_Ready;
  logic                   o_Taken;
  logic [WIDTH-1:0]       o_Target;
  logic [WIDTH-1:0]       o_RedirectPC;
  logic                   o_Mispredict;
  logic                   o_Misaligned;
  logic                   o_Illegal;
  logic [COUNT_WIDTH-1:0] o_BranchCount;
  logic [COUNT_WIDTH-1:0] o_MispredictCount;

  modport slave (
    input  i_Flush, i_Valid, i_IsBranch, i_IsJump, i_BranchOp, i_EQ, i_GT, i_LT,
           i_PC, i_Offset, i_PredTaken, i_PredTarget, i_Ready,
    output o_Ready, o_Valid, o_Taken, o_Target, o_RedirectPC, o_Mispredict,
           o_Misaligned, o_Illegal, o_BranchCount, o_MispredictCount
  );

  modport master (
    output i_Flush, i_Valid, i_IsBranch, i_IsJump, i_BranchOp, i_EQ, i_GT, i_LT,
           i_PC, i_Offset, i_PredTaken, i_PredTarget, i_Ready,
    input  o_Ready, o_Valid, o_Taken, o_Target, o_RedirectPC, o_Mispredict,
           o_Misaligned, o_Illegal, o_BranchCount, o_MispredictCount
  );
endinterface

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver.
// Combines comparer flags with the branch funct3 to resolve direction, computes
// the PC-relative target, checks the decode-stage prediction and flags a
// redirect on mispredict. One registered stage with valid/ready on both sides,
// flush, and saturating branch/mispredict statistics counters.
// Ports:
//   i_Clock  : clock, all state on rising edge
//   i_Reset  : synchronous active-high reset
//   bus      : branch_resolver_if.slave (entry in, result out, flush, counters)
module branch_resolver #(
  parameter int WIDTH       = 32,
  parameter int COUNT_WIDTH = 16,
  parameter bit COMPRESSED  = 1'b0
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  branch_resolver_if.slave bus
);

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLT  = 3'b100;
  localparam logic [2:0] OP_BGE  = 3'b101;
  localparam logic [2:0] OP_BLTU = 3'b110;
  localparam logic [2:0] OP_BGEU = 3'b111;

  logic                   valid_q, valid_d;
  logic                   taken_q, taken_d;
  logic [WIDTH-1:0]       target_q, target_d;
  logic [WIDTH-1:0]       redirect_q, redirect_d;
  logic                   mispred_q, mispred_d;
  logic                   misaligned_q, misaligned_d;
  logic                   illegal_q, illegal_d;
  logic                   counted_q, counted_d;
  logic [COUNT_WIDTH-1:0] bcount_q, bcount_d;
  logic [COUNT_WIDTH-1:0] mcount_q, mcount_d;

  logic             ready_c;
  logic             capture_c;
  logic             handshake_c;
  logic             illegal_c;
  logic             counted_c;
  logic             taken_c;
  logic [WIDTH-1:0] target_c;
  logic [WIDTH-1:0] seq_pc_c;

  // GT is not needed: GE is derived as !LT, which already covers EQ.
  logic unused_gt;
  assign unused_gt = bus.i_GT;

  assign ready_c     = !valid_q || bus.i_Ready;
  assign capture_c   = bus.i_Valid && ready_c && !bus.i_Flush;
  assign handshake_c = valid_q && bus.i_Ready;

  assign target_c = bus.i_PC + bus.i_Offset;
  assign seq_pc_c = bus.i_PC + WIDTH'(4);

  assign illegal_c = bus.i_IsBranch && (bus.i_BranchOp[2:1] == 2'b01);
  assign counted_c = (bus.i_IsBranch && !illegal_c) || bus.i_IsJump;

  always_comb begin
    taken_c = 1'b0;
    if (illegal_c) begin
      taken_c = 1'b0;
    end else if (bus.i_IsJump) begin
      taken_c = 1'b1;
    end else if (bus.i_IsBranch) begin
      case (bus.i_BranchOp)
        OP_BEQ:           taken_c = bus.i_EQ;
        OP_BNE:           taken_c = !bus.i_EQ;
        OP_BLT, OP_BLTU:  taken_c = bus.i_LT;
        OP_BGE, OP_BGEU:  taken_c = !bus.i_LT;
        default:          taken_c = 1'b0;
      endcase
    end
  end

  always_comb begin
    valid_d      = valid_q;
    taken_d      = taken_q;
    target_d     = target_q;
    redirect_d   = redirect_q;
    mispred_d    = mispred_q;
    misaligned_d = misaligned_q;
    illegal_d    = illegal_q;
    counted_d    = counted_q;
    bcount_d     = bcount_q;
    mcount_d     = mcount_q;

    // Flush wins over both capture and retirement of the held entry.
    if (bus.i_Flush) begin
      valid_d = 1'b0;
    end else begin
      if (handshake_c && counted_q) begin
        if (bcount_q != '1) bcount_d = bcount_q + COUNT_WIDTH'(1);
        if (mispred_q && (mcount_q != '1)) mcount_d = mcount_q + COUNT_WIDTH'(1);
      end
      if (capture_c) begin
        valid_d      = 1'b1;
        taken_d      = taken_c;
        target_d     = target_c;
        redirect_d   = taken_c ? target_c : seq_pc_c;
        mispred_d    = counted_c &&
                       ((taken_c != bus.i_PredTaken) ||
                        (taken_c && (bus.i_PredTarget != target_c)));
        misaligned_d = taken_c && (target_c[0] || (!COMPRESSED && target_c[1]));
        illegal_d    = illegal_c;
        counted_d    = counted_c;
      end else if (handshake_c) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
      target_q     <= '0;
      redirect_q   <= '0;
      mispred_q    <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      counted_q    <= 1'b0;
      bcount_q     <= '0;
      mcount_q     <= '0;
    end else begin
      valid_q      <= valid_d;
      taken_q      <= taken_d;
      target_q     <= target_d;
      redirect_q   <= redirect_d;
      mispred_q    <= mispred_d;
      misaligned_q <= misaligned_d;
      illegal_q    <= illegal_d;
      counted_q    <= counted_d;
      bcount_q     <= bcount_d;
      mcount_q     <= mcount_d;
    end
  end

  assign bus.o_Ready           = ready_c;
  assign bus.o_Valid           = valid_q;
  assign bus.o_Taken           = taken_q;
  assign bus.o_Target          = target_q;
  assign bus.o_RedirectPC      = redirect_q;
  assign bus.o_Mispredict      = mispred_q;
  assign bus.o_Misaligned      = misaligned_q;
  assign bus.o_Illegal         = illegal_q;
  assign bus.o_BranchCount     = bcount_q;
  assign bus.o_MispredictCount = mcount_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: a default-width instance plus a
// 4-bit-counter instance fed the same stimulus for the saturation corner.
module tb_branch_resolver;

  logic clk;
  logic rst;

  branch_resolver_if #(.WIDTH(32), .COUNT_WIDTH(16)) bif ();
  branch_resolver_if #(.WIDTH(32), .COUNT_WIDTH(4))  bif_s ();

  branch_resolver #(.WIDTH(32), .COUNT_WIDTH(16), .COMPRESSED(1'b0)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bif.slave)
  );

  branch_resolver #(.WIDTH(32), .COUNT_WIDTH(4), .COMPRESSED(1'b0)) dut_sat (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bif_s.slave)
  );

  assign bif_s.i_Flush      = bif.i_Flush;
  assign bif_s.i_Valid      = bif.i_Valid;
  assign bif_s.i_IsBranch   = bif.i_IsBranch;
  assign bif_s.i_IsJump     = bif.i_IsJump;
  assign bif_s.i_BranchOp   = bif.i_BranchOp;
  assign bif_s.i_EQ         = bif.i_EQ;
  assign bif_s.i_GT         = bif.i_GT;
  assign bif_s.i_LT         = bif.i_LT;
  assign bif_s.i_PC         = bif.i_PC;
  assign bif_s.i_Offset     = bif.i_Offset;
  assign bif_s.i_PredTaken  = bif.i_PredTaken;
  assign bif_s.i_PredTarget = bif.i_PredTarget;
  assign bif_s.i_Ready      = bif.i_Ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic        jp;
    logic [2:0]  op;
    logic        eq, gt, lt;
    logic [31:0] pc, off;
    logic        pt;
    logic [31:0] ptgt;
    logic        e_tk;
    logic [31:0] e_tgt, e_red;
    logic        e_mis, e_mal, e_ill, e_cnt;
  } vec_t;

  vec_t vecs[16];
  int checks = 0;
  int errors = 0;
  int exp_bc = 0;
  int exp_mc = 0;

  function automatic vec_t mk(logic br, logic jp, logic [2:0] op, logic eq, logic gt, logic lt,
                              logic [31:0] pc, logic [31:0] off, logic pt, logic [31:0] ptgt,
                              logic e_tk, logic [31:0] e_tgt, logic [31:0] e_red,
                              logic e_mis, logic e_mal, logic e_ill, logic e_cnt);
    vec_t v;
    v.br = br; v.jp = jp; v.op = op; v.eq = eq; v.gt = gt; v.lt = lt;
    v.pc = pc; v.off = off; v.pt = pt; v.ptgt = ptgt;
    v.e_tk = e_tk; v.e_tgt = e_tgt; v.e_red = e_red;
    v.e_mis = e_mis; v.e_mal = e_mal; v.e_ill = e_ill; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_counts(input string name);
    int sb, sm;
    sb = (exp_bc > 15) ? 15 : exp_bc;
    sm = (exp_mc > 15) ? 15 : exp_mc;
    chk({name, "_bc"},     32'(bif.o_BranchCount),       32'(exp_bc));
    chk({name, "_mc"},     32'(bif.o_MispredictCount),   32'(exp_mc));
    chk({name, "_bc_sat"}, 32'(bif_s.o_BranchCount),     32'(sb));
    chk({name, "_mc_sat"}, 32'(bif_s.o_MispredictCount), 32'(sm));
  endtask

  task automatic drive(input vec_t v, input logic valid);
    bif.i_Valid      = valid;
    bif.i_IsBranch   = v.br;
    bif.i_IsJump     = v.jp;
    bif.i_BranchOp   = v.op;
    bif.i_EQ         = v.eq;
    bif.i_GT         = v.gt;
    bif.i_LT         = v.lt;
    bif.i_PC         = v.pc;
    bif.i_Offset     = v.off;
    bif.i_PredTaken  = v.pt;
    bif.i_PredTarget = v.ptgt;
  endtask

  initial begin
    vec_t va, vb;
    //          br jp op     eq gt lt pc            off           pt ptgt          tk tgt           red           mis mal ill cnt
    vecs[0]  = mk(1, 0, 3'b000, 1, 0, 0, 32'h100,      32'h20,       0, 32'h0,        1, 32'h120,      32'h120,      1, 0, 0, 1);
    vecs[1]  = mk(1, 0, 3'b111, 0, 0, 1, 32'h200,      32'h40,       0, 32'h0,        0, 32'h240,      32'h204,      0, 0, 0, 1);
    vecs[2]  = mk(1, 0, 3'b001, 0, 1, 0, 32'h300,      32'hFFFFFFF0, 1, 32'h2F0,      1, 32'h2F0,      32'h2F0,      0, 0, 0, 1);
    vecs[3]  = mk(1, 0, 3'b001, 1, 0, 0, 32'h300,      32'h10,       1, 32'h310,      0, 32'h310,      32'h304,      1, 0, 0, 1);
    vecs[4]  = mk(1, 0, 3'b100, 0, 0, 1, 32'h400,      32'h8,        1, 32'h404,      1, 32'h408,      32'h408,      1, 0, 0, 1);
    vecs[5]  = mk(1, 0, 3'b101, 0, 0, 1, 32'h500,      32'h8,        1, 32'h508,      0, 32'h508,      32'h504,      1, 0, 0, 1);
    vecs[6]  = mk(1, 0, 3'b101, 0, 1, 0, 32'h600,      32'hC,        1, 32'h60C,      1, 32'h60C,      32'h60C,      0, 0, 0, 1);
    vecs[7]  = mk(1, 0, 3'b110, 1, 0, 0, 32'h700,      32'h10,       0, 32'h0,        0, 32'h710,      32'h704,      0, 0, 0, 1);
    vecs[8]  = mk(1, 0, 3'b010, 1, 0, 1, 32'h800,      32'h4,        1, 32'h804,      0, 32'h804,      32'h804,      0, 0, 1, 0);
    vecs[9]  = mk(1, 0, 3'b011, 0, 1, 0, 32'h900,      32'h4,        0, 32'h0,        0, 32'h904,      32'h904,      0, 0, 1, 0);
    vecs[10] = mk(0, 1, 3'b001, 1, 0, 0, 32'hFFFFFFFC, 32'h4,        1, 32'h0,        1, 32'h0,        32'h0,        0, 0, 0, 1);
    vecs[11] = mk(0, 1, 3'b000, 0, 0, 0, 32'h1000,     32'h2,        1, 32'h1002,     1, 32'h1002,     32'h1002,     0, 1, 0, 1);
    vecs[12] = mk(1, 0, 3'b000, 1, 0, 0, 32'h1000,     32'h1,        0, 32'h0,        1, 32'h1001,     32'h1001,     1, 1, 0, 1);
    vecs[13] = mk(1, 0, 3'b000, 0, 1, 0, 32'h1000,     32'h2,        0, 32'h0,        0, 32'h1002,     32'h1004,     0, 0, 0, 1);
    vecs[14] = mk(0, 0, 3'b000, 1, 0, 0, 32'h2000,     32'h8,        1, 32'h2008,     0, 32'h2008,     32'h2004,     0, 0, 0, 0);
    vecs[15] = mk(1, 0, 3'b100, 0, 1, 0, 32'hFFFFFFFC, 32'h0,        0, 32'h0,        0, 32'hFFFFFFFC, 32'h0,        0, 0, 0, 1);

    rst = 1'b1;
    bif.i_Flush = 1'b0;
    bif.i_Ready = 1'b1;
    drive(vecs[0], 1'b0);
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_valid",  32'(bif.o_Valid),  32'h0);
    chk("rst_ready",  32'(bif.o_Ready),  32'h1);
    chk("rst_target", bif.o_Target,      32'h0);
    chk("rst_redir",  bif.o_RedirectPC,  32'h0);
    chk("rst_taken",  32'(bif.o_Taken),  32'h0);
    chk_counts("rst");

    // Back-to-back table: each edge captures entry i and retires entry i-1.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i], 1'b1);
      step();
      if (i > 0) begin
        if (vecs[i-1].e_cnt) exp_bc++;
        if (vecs[i-1].e_cnt && vecs[i-1].e_mis) exp_mc++;
      end
      chk($sformatf("v%0d_valid", i), 32'(bif.o_Valid),      32'h1);
      chk($sformatf("v%0d_taken", i), 32'(bif.o_Taken),      32'(vecs[i].e_tk));
      chk($sformatf("v%0d_tgt",   i), bif.o_Target,          vecs[i].e_tgt);
      chk($sformatf("v%0d_red",   i), bif.o_RedirectPC,      vecs[i].e_red);
      chk($sformatf("v%0d_mis",   i), 32'(bif.o_Mispredict), 32'(vecs[i].e_mis));
      chk($sformatf("v%0d_mal",   i), 32'(bif.o_Misaligned), 32'(vecs[i].e_mal));
      chk($sformatf("v%0d_ill",   i), 32'(bif.o_Illegal),    32'(vecs[i].e_ill));
      chk_counts($sformatf("v%0d", i));
    end
    bif.i_Valid = 1'b0;
    step();
    if (vecs[15].e_cnt) exp_bc++;
    if (vecs[15].e_cnt && vecs[15].e_mis) exp_mc++;
    chk("drain_valid", 32'(bif.o_Valid), 32'h0);
    chk_counts("drain");

    // Backpressure: held entry must stay stable for 4 stalled cycles.
    va = mk(1, 0, 3'b000, 1, 0, 0, 32'h3000, 32'h40, 0, 32'h0, 1, 32'h3040, 32'h3040, 1, 0, 0, 1);
    vb = mk(0, 1, 3'b000, 0, 0, 0, 32'h4000, 32'h10, 1, 32'h4010, 1, 32'h4010, 32'h4010, 0, 0, 0, 1);
    drive(va, 1'b1);
    step();
    chk("st_cap_valid", 32'(bif.o_Valid), 32'h1);
    drive(vb, 1'b1);
    bif.i_Ready = 1'b0;
    #1;
    chk("st_ready0", 32'(bif.o_Ready), 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("st%0d_valid", k), 32'(bif.o_Valid),      32'h1);
      chk($sformatf("st%0d_tgt",   k), bif.o_Target,          32'h3040);
      chk($sformatf("st%0d_mis",   k), 32'(bif.o_Mispredict), 32'h1);
      chk($sformatf("st%0d_ready", k), 32'(bif.o_Ready),      32'h0);
      chk_counts($sformatf("st%0d", k));
    end
    bif.i_Ready = 1'b1;
    #1;
    chk("st_ready1", 32'(bif.o_Ready), 32'h1);
    step();
    exp_bc++;
    exp_mc++;
    chk("st_rel_valid", 32'(bif.o_Valid),      32'h1);
    chk("st_rel_tgt",   bif.o_Target,          32'h4010);
    chk("st_rel_mis",   32'(bif.o_Mispredict), 32'h0);
    chk_counts("st_rel");
    bif.i_Valid = 1'b0;
    step();
    exp_bc++;
    chk("st_drain_valid", 32'(bif.o_Valid), 32'h0);
    chk_counts("st_drain");

    // Flush with held entry and new input in the same cycle.
    drive(va, 1'b1);
    step();
    chk("fl_cap_valid", 32'(bif.o_Valid), 32'h1);
    drive(vb, 1'b1);
    bif.i_Flush = 1'b1;
    #1;
    chk("fl_ready", 32'(bif.o_Ready), 32'h1);
    step();
    chk("fl_valid", 32'(bif.o_Valid), 32'h0);
    chk_counts("fl");
    bif.i_Flush = 1'b0;
    bif.i_Valid = 1'b0;
    step();
    chk("fl_after_valid", 32'(bif.o_Valid), 32'h0);
    chk_counts("fl_after");

    // Saturation: 20 mispredicting branches.
    for (int k = 0; k < 20; k++) begin
      va.pc = 32'h7000 + 32'(k * 4);
      drive(va, 1'b1);
      step();
    end
    bif.i_Valid = 1'b0;
    step();
    exp_bc += 20;
    exp_mc += 20;
    chk_counts("sat");

    // Reset while an entry is held and stalled.
    drive(vb, 1'b1);
    step();
    bif.i_Ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bif.i_Valid = 1'b0;
    bif.i_Ready = 1'b1;
    exp_bc = 0;
    exp_mc = 0;
    chk("mrst_valid",  32'(bif.o_Valid), 32'h0);
    chk("mrst_target", bif.o_Target,     32'h0);
    chk_counts("mrst");
    step();
    chk("mrst_after_valid", 32'(bif.o_Valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
